gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq: RTL and testbench

Synchronous write sequencer that sits directly upstream of a bank of latsnq_2 latches. It generates the D, E and SETN pins for DEPTH words of WIDTH latches. It turns a clocked request/ready write into a glitch-free setup/enable-pulse/hold sequence per word. It also drives the array-wide active-low preset, automatically after reset and on demand.

---
 rtl/latsnq_wr_seq_pkg.sv | 32 +++
 rtl/latsnq_wr_seq_cnt.sv | 25 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv | 130 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/latsnq_wr_seq_pkg.sv
// rtl/latsnq_wr_seq_pkg.sv - shared types and helpers for the latsnq_2 write sequencer
package latsnq_wr_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRESET,
    ST_RECOVER,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  // Width of the shared phase counter: enough for the longest phase, plus one bit.
  function automatic int cnt_w(input int setup_cyc, input int pulse_cyc,
                               input int hold_cyc, input int preset_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (preset_cyc > m) m = preset_cyc;
    return $clog2(m) + 1;
  endfunction

  // One-hot word enable; an index at or beyond depth selects nothing.
  function automatic logic [31:0] onehot_dec(input int unsigned idx, input int unsigned depth);
    logic [31:0] v;
    v = '0;
    if (idx < depth && idx < 32) v = 32'd1 << idx;
    return v;
  endfunction

endpackage

// File: rtl/latsnq_wr_seq_cnt.sv
// rtl/latsnq_wr_seq_cnt.sv - loadable phase down-counter with a zero flag
module latsnq_wr_seq_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Reset is expressed by the owner as a load; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv - setup/enable-pulse/hold write sequencer for a latsnq_2 bank
module gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq
  import latsnq_wr_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int PRESET_CYC = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  output logic             READY,
  input  logic [AW-1:0]    ADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             PRESET_REQ,
  output logic [WIDTH-1:0] D,
  output logic [DEPTH-1:0] E,
  output logic             SETN,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY
);

  localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC, PRESET_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] PRESET_LD = CW'(PRESET_CYC - 1);
  localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(DEPTH);

  state_t          state, state_n;
  logic            cnt_load;
  logic [CW-1:0]   cnt_val;
  logic            cnt_zero;
  logic            accept;
  logic [AW-1:0]   addr_q;
  logic            oor_q;
  logic [DEPTH-1:0] e_dec;
  logic            finish;

  latsnq_wr_seq_cnt #(.W(CW)) u_cnt (
    .clk      (CLK),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (~cnt_load),
    .zero     (cnt_zero)
  );

  assign READY  = (state == ST_IDLE) && !PRESET_REQ;
  assign BUSY   = (state != ST_IDLE);
  assign e_dec  = DEPTH'(onehot_dec(32'(addr_q), 32'(DEPTH)));
  assign finish = (state == ST_HOLD) && (state_n == ST_IDLE);

  // Each phase lasts (load value + 1) cycles: the counter is loaded on entry
  // and the phase is left on the cycle it reads zero.
  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    case (state)
      ST_PRESET: if (cnt_zero) state_n = ST_RECOVER;
      ST_RECOVER: state_n = ST_IDLE;
      ST_IDLE: begin
        if (PRESET_REQ) begin
          state_n  = ST_PRESET;
          cnt_load = 1'b1;
          cnt_val  = PRESET_LD;
        end else if (REQ) begin
          accept   = 1'b1;
          state_n  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_SETUP: if (cnt_zero) begin
        state_n  = ST_PULSE;
        cnt_load = 1'b1;
        cnt_val  = PULSE_LD;
      end
      ST_PULSE: if (cnt_zero) begin
        state_n  = ST_HOLD;
        cnt_load = 1'b1;
        cnt_val  = HOLD_LD;
      end
      ST_HOLD: if (cnt_zero) state_n = ST_IDLE;
      default: state_n = ST_PRESET;
    endcase
    if (RST) begin
      state_n  = ST_PRESET;
      cnt_load = 1'b1;
      cnt_val  = PRESET_LD;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_PRESET;
      addr_q <= '0;
      oor_q  <= 1'b0;
      D      <= '0;
      E      <= '0;
      SETN   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state <= state_n;
      SETN  <= (state_n != ST_PRESET);
      DONE  <= finish;
      ERR   <= finish && oor_q;
      if (accept) begin
        addr_q <= ADDR;
        oor_q  <= ({1'b0, ADDR} >= DEPTH_V);
        D      <= WDATA;
      end
      // E moves only on the phase edges, never while D can change.
      if (state == ST_SETUP && state_n == ST_PULSE) begin
        E <= e_dec;
      end else if (state == ST_PULSE && state_n == ST_HOLD) begin
        E <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq.sv - self-checking bench for the latsnq_2 write sequencer
module tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int PC = 2;

  logic       CLK = 1'b0;
  logic       RST, REQ, PRESET_REQ;
  logic [1:0] ADDR;
  logic [7:0] WDATA;

  logic       ready0, setn0, done0, err0, busy0;
  logic [7:0] d0;
  logic [3:0] e0;
  logic       ready1, setn1, done1, err1, busy1;
  logic [7:0] d1;
  logic [2:0] e1;

  int n_assert = 0;
  int n_fail   = 0;
  int c        = 0;

  // Timeline model: every output is a function of the current cycle number
  // and a handful of windows scheduled when an event is accepted.
  int         idle_from = 1 << 30;
  int         setn_lo   = 0;
  int         setn_hi   = -1;
  int         e_lo      = 1;
  int         e_hi      = 0;
  int         done_cyc  = -1;
  logic [7:0] d_exp     = 8'h00;
  int         depth_m [2] = '{4, 3};
  logic [3:0] e_val [2];
  logic       err_flag [2];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq dut4 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .READY(ready0), .ADDR(ADDR), .WDATA(WDATA),
    .PRESET_REQ(PRESET_REQ), .D(d0), .E(e0), .SETN(setn0), .DONE(done0),
    .ERR(err0), .BUSY(busy0)
  );

  gf180mcu_fd_sc_mcu9t5v0__latsnq_wr_seq #(.DEPTH(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .READY(ready1), .ADDR(ADDR), .WDATA(WDATA),
    .PRESET_REQ(PRESET_REQ), .D(d1), .E(e1), .SETN(setn1), .DONE(done1),
    .ERR(err1), .BUSY(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic req, input logic preq,
                      input logic [1:0] addr, input logic [7:0] wd);
    logic       busy_e, ready_e, setn_e, done_e, e_on;
    logic [3:0] e0_e, e1_e;
    RST = rst; REQ = req; PRESET_REQ = preq; ADDR = addr; WDATA = wd;
    #1;
    if (c >= 1) begin
      busy_e  = (c < idle_from);
      ready_e = !busy_e && !preq;
      setn_e  = !(c >= setn_lo && c <= setn_hi);
      done_e  = (c == done_cyc);
      e_on    = (c >= e_lo && c <= e_hi);
      e0_e    = e_on ? e_val[0] : 4'h0;
      e1_e    = e_on ? e_val[1] : 4'h0;
      chk("ready4", 32'(ready0), 32'(ready_e));
      chk("busy4",  32'(busy0),  32'(busy_e));
      chk("setn4",  32'(setn0),  32'(setn_e));
      chk("e4",     32'(e0),     32'(e0_e));
      chk("d4",     32'(d0),     32'(d_exp));
      chk("done4",  32'(done0),  32'(done_e));
      chk("err4",   32'(err0),   32'(done_e && err_flag[0]));
      chk("ready3", 32'(ready1), 32'(ready_e));
      chk("setn3",  32'(setn1),  32'(setn_e));
      chk("e3",     32'(e1),     32'(e1_e));
      chk("d3",     32'(d1),     32'(d_exp));
      chk("done3",  32'(done1),  32'(done_e));
      chk("err3",   32'(err1),   32'(done_e && err_flag[1]));
    end
    if (rst) begin
      if (!(c >= setn_lo && c <= setn_hi)) setn_lo = c + 1;
      setn_hi   = c + PC;
      idle_from = c + PC + 2;
      if (e_hi > c) e_hi = c;
      if (done_cyc > c) done_cyc = -1;
      d_exp = 8'h00;
    end else if (c >= idle_from) begin
      if (preq) begin
        setn_lo   = c + 1;
        setn_hi   = c + PC;
        idle_from = c + PC + 2;
      end else if (req) begin
        d_exp     = wd;
        e_lo      = c + S + 1;
        e_hi      = c + S + P;
        done_cyc  = c + S + P + H + 1;
        idle_from = c + S + P + H + 1;
        for (int k = 0; k < 2; k++) begin
          e_val[k]    = (int'(addr) < depth_m[k]) ? (4'b0001 << addr) : 4'b0000;
          err_flag[k] = (int'(addr) >= depth_m[k]);
        end
      end
    end
    @(negedge CLK);
    c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    e_val[0] = 4'h0; e_val[1] = 4'h0;
    err_flag[0] = 1'b0; err_flag[1] = 1'b0;

    // reset release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    idle(5);

    // single write
    step(1'b0, 1'b1, 1'b0, 2'd2, 8'hA5);
    idle(6);

    // back-to-back with REQ held
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h3C);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 2'd3, 8'hC3);
    idle(6);

    // preset request beats a simultaneous write
    step(1'b0, 1'b1, 1'b1, 2'd1, 8'h11);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd1, 8'h22);
    idle(6);

    // reset during the enable pulse
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'h5A);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    idle(6);

    // address 3: out of range on the three-word instance only
    step(1'b0, 1'b1, 1'b0, 2'd3, 8'h77);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 2) == 0, ($urandom % 8) == 0,
           2'($urandom % 4), 8'($urandom));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
